// File: rtl/aes_mixcol_ark_if.sv
// Bundle between the ShiftRows stage, this stage and the next SubBytes stage.
// AES_MC_PARITY_EN adds parity_out[15:0].
interface aes_mixcol_ark_if;
  logic [127:0] state_in;
  logic [127:0] key_in;
  logic [31:0]  srw_in;
  logic [7:0]   rcon_in;
  logic         empty_in;
  logic         hold;
  logic [127:0] state_out;
  logic [127:0] key_out;
  logic [7:0]   rcon_out;
  logic         empty;
`ifdef AES_MC_PARITY_EN
  logic [15:0]  parity_out;

  modport master (
    output state_in, key_in, srw_in,
    output rcon_in, empty_in, hold,
    input  state_out, key_out,
    input  rcon_out, empty, parity_out
  );
  modport slave (
    input  state_in, key_in, srw_in,
    input  rcon_in, empty_in, hold,
    output state_out, key_out,
    output rcon_out, empty, parity_out
  );
`else
  modport master (
    output state_in, key_in, srw_in,
    output rcon_in, empty_in, hold,
    input  state_out, key_out,
    input  rcon_out, empty
  );
  modport slave (
    input  state_in, key_in, srw_in,
    input  rcon_in, empty_in, hold,
    output state_out, key_out,
    output rcon_out, empty
  );
`endif
endinterface

// File: rtl/aes_mixcol_ark.sv
// AES-128 MixColumns + AddRoundKey stage with on-the-fly key expansion.
// 2-cycle pipe with global hold; AES_MC_PARITY_EN adds byte parity.
module aes_mixcol_ark #(
  parameter logic [7:0] LAST_RCON = 8'h36,
  parameter logic [7:0] RCON_POLY = 8'h1B
) (
  input  logic         clock,
  input  logic         resetn,
  aes_mixcol_ark_if.slave bus
);

  function automatic logic [7:0] xt(
    input logic [7:0] x
  );
    return {x[6:0], 1'b0} ^
           (x[7] ? RCON_POLY : 8'h00);
  endfunction

  // column word: row 0 in the MSB
  function automatic logic [31:0] col(
    input logic [127:0] s,
    input int           c
  );
    return {s[8*c +: 8], s[8*(4+c) +: 8],
            s[8*(8+c) +: 8], s[8*(12+c) +: 8]};
  endfunction

  function automatic logic [31:0] mix(
    input logic [31:0] x
  );
    logic [7:0] b0, b1, b2, b3;
    logic [7:0] r0, r1, r2, r3;
    b0 = x[31:24];
    b1 = x[23:16];
    b2 = x[15:8];
    b3 = x[7:0];
    r0 = xt(b0) ^ xt(b1) ^ b1 ^ b2 ^ b3;
    r1 = b0 ^ xt(b1) ^ xt(b2) ^ b2 ^ b3;
    r2 = b0 ^ b1 ^ xt(b2) ^ xt(b3) ^ b3;
    r3 = xt(b0) ^ b0 ^ b1 ^ b2 ^ xt(b3);
    return {r0, r1, r2, r3};
  endfunction

  logic [127:0] s1_state_q, s1_state_d;
  logic [127:0] s1_key_q, s1_key_d;
  logic [7:0]   s1_rcon_q, s1_rcon_d;
  logic         s1_last_q, s1_last_d;
  logic         s1_empty_q;

  logic [127:0] s2_state_q, s2_state_d;
  logic [127:0] s2_key_q;
  logic [7:0]   s2_rcon_q;
  logic         s2_empty_q;
`ifdef AES_MC_PARITY_EN
  logic [15:0]  s2_par_q, s2_par_d;
`endif

  always_comb begin
    logic [31:0] nk;
    s1_state_d = bus.state_in;
    s1_rcon_d  = xt(bus.rcon_in);
    s1_last_d  = (bus.rcon_in == LAST_RCON);
    s1_key_d   = '0;
    nk = col(bus.key_in, 0) ^ bus.srw_in ^
         {bus.rcon_in, 24'h0};
    for (int c = 0; c < 4; c++) begin
      if (c != 0) nk = nk ^ col(bus.key_in, c);
      s1_key_d[8*c +: 8]      = nk[31:24];
      s1_key_d[8*(4+c) +: 8]  = nk[23:16];
      s1_key_d[8*(8+c) +: 8]  = nk[15:8];
      s1_key_d[8*(12+c) +: 8] = nk[7:0];
    end
  end

  always_comb begin
    logic [31:0] m;
    s2_state_d = '0;
    for (int c = 0; c < 4; c++) begin
      m = col(s1_state_q, c);
      if (!s1_last_q) m = mix(m);
      s2_state_d[8*c +: 8]      = m[31:24];
      s2_state_d[8*(4+c) +: 8]  = m[23:16];
      s2_state_d[8*(8+c) +: 8]  = m[15:8];
      s2_state_d[8*(12+c) +: 8] = m[7:0];
    end
    s2_state_d = s2_state_d ^ s1_key_q;
  end

`ifdef AES_MC_PARITY_EN
  always_comb begin
    s2_par_d = '0;
    for (int i = 0; i < 16; i++)
      s2_par_d[i] = ^s2_state_d[8*i +: 8];
  end
`endif

  // empty slots still load the datapath; only empty gates use
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1_state_q <= '0;
      s1_key_q   <= '0;
      s1_rcon_q  <= '0;
      s1_last_q  <= 1'b0;
      s1_empty_q <= 1'b1;
      s2_state_q <= '0;
      s2_key_q   <= '0;
      s2_rcon_q  <= '0;
      s2_empty_q <= 1'b1;
`ifdef AES_MC_PARITY_EN
      s2_par_q   <= '0;
`endif
    end else if (!bus.hold) begin
      s1_state_q <= s1_state_d;
      s1_key_q   <= s1_key_d;
      s1_rcon_q  <= s1_rcon_d;
      s1_last_q  <= s1_last_d;
      s1_empty_q <= bus.empty_in;
      s2_state_q <= s2_state_d;
      s2_key_q   <= s1_key_q;
      s2_rcon_q  <= s1_rcon_q;
      s2_empty_q <= s1_empty_q;
`ifdef AES_MC_PARITY_EN
      s2_par_q   <= s2_par_d;
`endif
    end
  end

  assign bus.state_out = s2_state_q;
  assign bus.key_out   = s2_key_q;
  assign bus.rcon_out  = s2_rcon_q;
  assign bus.empty     = s2_empty_q;
`ifdef AES_MC_PARITY_EN
  assign bus.parity_out = s2_par_q;
`endif

endmodule

// File: tb/tb_aes_mixcol_ark.sv
// Scoreboard bench for aes_mixcol_ark: driver queues expected
// results, monitor pops them as the pipe advances.
module tb_aes_mixcol_ark;

  typedef struct {
    logic [127:0] st;
    logic [127:0] key;
    logic [31:0]  srw;
    logic [7:0]   rcon;
    logic [127:0] e_st;
    logic [127:0] e_key;
    logic [7:0]   e_rcon;
  } vec_t;

  typedef struct {
    logic [127:0] st;
    logic [127:0] key;
    logic [7:0]   rcon;
    logic         empty;
    logic         chk;
  } exp_t;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  bit   done = 1'b0;
  bit   fire;
  bit   cnt;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  vec_t v[6];

  aes_mixcol_ark_if bus();

  aes_mixcol_ark dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  function automatic logic [127:0] pk(
    input logic [31:0] w0, input logic [31:0] w1,
    input logic [31:0] w2, input logic [31:0] w3
  );
    logic [127:0] s;
    logic [31:0]  w[4];
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[8*(4*r+c) +: 8] = w[c][31-8*r -: 8];
    return s;
  endfunction

  // tracks whether the output changes at this edge
  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      fire <= 1'b0;
      cnt  <= 1'b0;
    end else begin
      fire <= !bus.hold && cnt;
      if (!bus.hold) cnt <= 1'b1;
    end
  end

  task automatic chk(
    input string nm,
    input logic [127:0] act,
    input logic [127:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  initial begin
    exp_t cur;
    exp_t rst;
    rst = '{128'h0, 128'h0, 8'h0, 1'b1, 1'b1};
    cur = rst;
    while (!done) begin
      @(negedge clock or negedge resetn);
      #1;
      if (!resetn) begin
        q.delete();
        cur = rst;
      end else if (fire) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL underflow: got output, expected none");
        end else begin
          cur = q.pop_front();
        end
      end
      chk("empty", {127'h0, bus.empty}, {127'h0, cur.empty});
      if (cur.chk) begin
        chk("state", bus.state_out, cur.st);
        chk("key", bus.key_out, cur.key);
        chk("rcon", {120'h0, bus.rcon_out}, {120'h0, cur.rcon});
`ifdef AES_MC_PARITY_EN
        begin
          logic [15:0] p;
          for (int i = 0; i < 16; i++) p[i] = ^cur.st[8*i +: 8];
          chk("parity", {112'h0, bus.parity_out}, {112'h0, p});
        end
`endif
      end
    end
    chk("leftover", 128'(q.size()), 128'h0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim did not end, expected done");
    $fatal(1);
  end

  task automatic issue(input vec_t x, input bit e);
    bus.state_in = x.st;
    bus.key_in   = x.key;
    bus.srw_in   = x.srw;
    bus.rcon_in  = x.rcon;
    bus.empty_in = e;
    bus.hold     = 1'b0;
    q.push_back('{x.e_st, x.e_key, x.e_rcon, e, !e});
    @(posedge clock);
    #1;
  endtask

  task automatic stall(input int n);
    bus.hold     = 1'b1;
    bus.state_in = v[1].st;
    bus.key_in   = v[1].key;
    bus.rcon_in  = 8'h55;
    bus.empty_in = 1'b0;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
    bus.hold = 1'b0;
  endtask

  initial begin
    logic [127:0] k1, db4, k01, k36;
    k01 = pk(32'h01000000, 32'h01000000,
             32'h01000000, 32'h01000000);
    k36 = pk(32'h36000000, 32'h36000000,
             32'h36000000, 32'h36000000);
    db4 = pk(32'hdb135345, 32'hdb135345,
             32'hdb135345, 32'hdb135345);
    k1  = pk(32'ha0fafe17, 32'h88542cb1,
             32'h23a33939, 32'h2a6c7605);
    v[0] = '{pk(32'hdb135345, 32'hf20a225c,
                32'hd4d4d4d5, 32'h2d26314c),
             128'h0, 32'h0, 8'h01,
             pk(32'h8f4da1bc, 32'h9edc589d,
                32'hd4d5d7d6, 32'h4c7ebdf8),
             k01, 8'h02};
    v[1] = '{128'h0,
             pk(32'h2b7e1516, 32'h28aed2a6,
                32'habf71588, 32'h09cf4f3c),
             32'h8a84eb01, 8'h01, k1, k1, 8'h02};
    v[2] = '{128'h0, 128'h0, 32'h0, 8'h36,
             k36, k36, 8'h6c};
    v[3] = '{db4, 128'h0, 32'h0, 8'h36,
             pk(32'hed135345, 32'hed135345,
                32'hed135345, 32'hed135345),
             k36, 8'h6c};
    v[4] = '{128'h0, 128'h0, 32'h0, 8'h80,
             pk(32'h80000000, 32'h80000000,
                32'h80000000, 32'h80000000),
             pk(32'h80000000, 32'h80000000,
                32'h80000000, 32'h80000000),
             8'h1b};
    v[5] = '{db4, 128'h0, 32'h0, 8'h01,
             pk(32'h8f4da1bc, 32'h8f4da1bc,
                32'h8f4da1bc, 32'h8f4da1bc),
             k01, 8'h02};

    bus.state_in = '0;
    bus.key_in   = '0;
    bus.srw_in   = '0;
    bus.rcon_in  = '0;
    bus.empty_in = 1'b0;
    bus.hold     = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b1;

    for (int i = 0; i < 6; i++) issue(v[i], 1'b0);

    for (int i = 0; i < 3; i++) begin
      issue(v[i], 1'b1);
      issue(v[i], 1'b0);
    end

    issue(v[3], 1'b0);
    issue(v[4], 1'b0);
    stall(3);
    issue(v[5], 1'b0);
    issue(v[0], 1'b0);

    issue(v[1], 1'b0);
    issue(v[2], 1'b0);
    #2;
    resetn = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b1;
    issue(v[4], 1'b0);
    issue(v[3], 1'b0);
    repeat (3) issue(v[0], 1'b1);
    @(posedge clock);
    #1;
    done = 1'b1;
  end

endmodule
